// File: rtl/reaction_timer_if.sv
// reaction_timer_if
//   Bundles the round-control handshake between the game controller
//   (master: drives start/button/rand_val) and reaction_timer (slave).
//
//   start        controller -> timer   one-cycle pulse, begins a round
//   button       controller -> timer   debounced one-cycle press pulse
//   rand_val     controller -> timer   current 12-bit LFSR value
//   rand_step    timer -> controller   one-cycle pulse to advance the LFSR
//   busy         timer -> controller   round in progress (WAIT or GO)
//   led_go       timer -> controller   "go" lamp
//   done         timer -> controller   one-cycle pulse on entry to RESULT
//   rt_ms        timer -> controller   measured reaction time (ticks)
//   timeout      timer -> controller   round ended at the ceiling
//   false_start  timer -> controller   round aborted by an early press
interface reaction_timer_if;
    logic        start;
    logic        button;
    logic [11:0] rand_val;
    logic        rand_step;
    logic        busy;
    logic        led_go;
    logic        done;
    logic [13:0] rt_ms;
    logic        timeout;
    logic        false_start;

    modport master (
        output start, button, rand_val,
        input  rand_step, busy, led_go, done, rt_ms, timeout, false_start
    );

    modport slave (
        input  start, button, rand_val,
        output rand_step, busy, led_go, done, rt_ms, timeout, false_start
    );
endinterface

// File: rtl/reaction_timer.sv
// reaction_timer
//   One round of the reaction game: random pre-go delay of
//   MIN_DELAY_MS + rand_val ticks, a "go" indication, then measurement of
//   the response time in ticks (one tick = CLK_HZ/TICK_HZ clocks).
//
//   Ports
//     i_clk   system clock, rising edge
//     i_rst   asynchronous active-high reset
//     bus     reaction_timer_if.slave (start/button/rand_val in,
//             rand_step/busy/led_go/done/rt_ms/timeout/false_start out)
//
//   Build option
//     REACTION_FALSE_START_EN  when defined, a press during WAIT ends the
//                              round with false_start=1; otherwise such a
//                              press is ignored and false_start is tied 0.
//
//   state    | meaning
//   ---------+------------------------------------------------------
//   S_IDLE   | after reset, waiting for start
//   S_WAIT   | counting down the random pre-go delay
//   S_GO     | led_go lit, counting reaction time
//   S_RESULT | rt_ms and flags held, waiting for the next start
module reaction_timer #(
    parameter int CLK_HZ       = 50000000,
    parameter int TICK_HZ      = 1000,
    parameter int MIN_DELAY_MS = 1000,
    parameter int MAX_RT_MS    = 9999
) (
    input  logic              i_clk,
    input  logic              i_rst,
    reaction_timer_if.slave   bus
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [PW-1:0] PRESC_TC = PW'(DIV - 1);
    localparam logic [13:0]   MIN_D    = 14'(MIN_DELAY_MS);
    localparam logic [13:0]   MAX_RT   = 14'(MAX_RT_MS);
    localparam logic [13:0]   RT_LAST  = 14'(MAX_RT_MS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_GO,
        S_RESULT
    } state_t;

    state_t        r_state;
    logic [PW-1:0] r_presc;
    logic [13:0]   r_delay;
    logic [13:0]   r_rt_cnt;
    logic          r_rand_step;
    logic          r_busy;
    logic          r_led_go;
    logic          r_done;
    logic [13:0]   r_rt_ms;
    logic          r_timeout;
`ifdef REACTION_FALSE_START_EN
    logic          r_false_start;
`endif

    logic w_tick;

    assign w_tick = (r_presc == PRESC_TC);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_presc     <= '0;
            r_delay     <= '0;
            r_rt_cnt    <= '0;
            r_rand_step <= 1'b0;
            r_busy      <= 1'b0;
            r_led_go    <= 1'b0;
            r_done      <= 1'b0;
            r_rt_ms     <= '0;
            r_timeout   <= 1'b0;
`ifdef REACTION_FALSE_START_EN
            r_false_start <= 1'b0;
`endif
        end else begin
            r_rand_step <= 1'b0;
            r_done      <= 1'b0;

            case (r_state)
                S_IDLE, S_RESULT: begin
                    if (bus.start) begin
                        r_state     <= S_WAIT;
                        // 14 bits cover 12000 + 4095 without overflow.
                        r_delay     <= MIN_D + {2'b00, bus.rand_val};
                        r_presc     <= '0;
                        r_rand_step <= 1'b1;
                        r_busy      <= 1'b1;
                        r_rt_ms     <= '0;
                        r_timeout   <= 1'b0;
`ifdef REACTION_FALSE_START_EN
                        r_false_start <= 1'b0;
`endif
                    end
                end

                S_WAIT: begin
`ifdef REACTION_FALSE_START_EN
                    if (bus.button) begin
                        r_state       <= S_RESULT;
                        r_busy        <= 1'b0;
                        r_done        <= 1'b1;
                        r_rt_ms       <= '0;
                        r_false_start <= 1'b1;
                    end else
`endif
                    if (w_tick) begin
                        // Clearing here also restarts the prescaler on GO entry.
                        r_presc <= '0;
                        if (r_delay == 14'd1) begin
                            r_state  <= S_GO;
                            r_led_go <= 1'b1;
                            r_rt_cnt <= '0;
                        end else begin
                            r_delay <= r_delay - 14'd1;
                        end
                    end else begin
                        r_presc <= r_presc + 1'b1;
                    end
                end

                S_GO: begin
                    // A press wins over a same-cycle tick: capture before increment.
                    if (bus.button) begin
                        r_state  <= S_RESULT;
                        r_busy   <= 1'b0;
                        r_led_go <= 1'b0;
                        r_done   <= 1'b1;
                        r_rt_ms  <= r_rt_cnt;
                    end else if (w_tick) begin
                        r_presc <= '0;
                        if (r_rt_cnt == RT_LAST) begin
                            r_state   <= S_RESULT;
                            r_busy    <= 1'b0;
                            r_led_go  <= 1'b0;
                            r_done    <= 1'b1;
                            r_rt_ms   <= MAX_RT;
                            r_timeout <= 1'b1;
                        end else begin
                            r_rt_cnt <= r_rt_cnt + 14'd1;
                        end
                    end else begin
                        r_presc <= r_presc + 1'b1;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.rand_step = r_rand_step;
    assign bus.busy      = r_busy;
    assign bus.led_go    = r_led_go;
    assign bus.done      = r_done;
    assign bus.rt_ms     = r_rt_ms;
    assign bus.timeout   = r_timeout;
`ifdef REACTION_FALSE_START_EN
    assign bus.false_start = r_false_start;
`else
    assign bus.false_start = 1'b0;
`endif

endmodule

// File: tb/tb_reaction_timer.sv
// Bench for reaction_timer: 10 clocks per tick, MIN_DELAY_MS=5, MAX_RT_MS=20.
// Expected round results are queued when stimulus is issued; a monitor pops
// and compares whenever done pulses.
module tb_reaction_timer;
    localparam int CLK_HZ       = 1000;
    localparam int TICK_HZ      = 100;
    localparam int MIN_DELAY_MS = 5;
    localparam int MAX_RT_MS    = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    reaction_timer_if bus ();

    reaction_timer #(
        .CLK_HZ      (CLK_HZ),
        .TICK_HZ     (TICK_HZ),
        .MIN_DELAY_MS(MIN_DELAY_MS),
        .MAX_RT_MS   (MAX_RT_MS)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus.slave)
    );

    typedef struct packed {
        logic [13:0] rt;
        logic        to;
        logic        fs;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   done_seen = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin : mon_blk
        exp_t e;
        if (!rst && bus.done === 1'b1) begin
            done_seen++;
            if (sb_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("sb_rt_ms",       int'(bus.rt_ms),       int'(e.rt));
                check("sb_timeout",     int'(bus.timeout),     int'(e.to));
                check("sb_false_start", int'(bus.false_start), int'(e.fs));
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},        int'(bus.busy),        0);
        check({tag, "_led_go"},      int'(bus.led_go),      0);
        check({tag, "_done"},        int'(bus.done),        0);
        check({tag, "_rt_ms"},       int'(bus.rt_ms),       0);
        check({tag, "_timeout"},     int'(bus.timeout),     0);
        check({tag, "_false_start"}, int'(bus.false_start), 0);
        check({tag, "_rand_step"},   int'(bus.rand_step),   0);
    endtask

    initial begin
        int first_go;
        int done_k;
        int extra_steps;
        int done_base;
        int go_seen;

        bus.start    = 1'b0;
        bus.button   = 1'b0;
        bus.rand_val = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Round A: rand_val=3 -> D=8; stray starts in WAIT (k=20) and GO (k=100);
        // press sampled on the 8th GO tick edge -> rt_ms=7.
        bus.rand_val = 12'd3;
        bus.start    = 1'b1;
        first_go = -1; done_k = -1; extra_steps = 0;
        for (int k = 0; k <= 200; k++) begin
            @(negedge clk);
            bus.start  = (k == 20 || k == 100);
            bus.button = (k == 159);
            if (k == 159) sb_q.push_back(exp_t'{14'd7, 1'b0, 1'b0});
            if (k == 0) begin
                check("a_rand_step_k0", int'(bus.rand_step), 1);
                check("a_busy_k0",      int'(bus.busy),      1);
            end
            if (k == 1) check("a_rand_step_k1", int'(bus.rand_step), 0);
            if (k > 0 && bus.rand_step) extra_steps++;
            if (bus.led_go && first_go < 0) first_go = k;
            if (bus.done && done_k < 0) done_k = k;
            if (k == 160) check("a_led_go_low", int'(bus.led_go), 0);
            if (k == 161) check("a_done_width", int'(bus.done), 0);
        end
        check("a_go_cycle",     first_go,    80);
        check("a_done_cycle",   done_k,      160);
        check("a_extra_steps",  extra_steps, 0);

        // Round B: rand_val=0 -> D=5; no press -> timeout after 20 GO ticks.
        bus.rand_val = 12'd0;
        bus.start    = 1'b1;
        sb_q.push_back(exp_t'{14'd20, 1'b1, 1'b0});
        first_go = -1; done_k = -1; done_base = done_seen;
        for (int k = 0; k <= 260; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.led_go && first_go < 0) first_go = k;
            if (bus.done && done_k < 0) done_k = k;
        end
        check("b_go_cycle",   first_go,                50);
        check("b_done_cycle", done_k,                  250);
        check("b_done_count", done_seen - done_base,   1);
        check("b_rt_hold",    int'(bus.rt_ms),         20);
        check("b_to_hold",    int'(bus.timeout),       1);

        // Round C: rand_val=2 -> D=7; press 2 ticks into WAIT.
        bus.rand_val = 12'd2;
        bus.start    = 1'b1;
        first_go = -1; done_k = -1; go_seen = 0;
        for (int k = 0; k <= 120; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (k == 0) begin
                check("c_rt_cleared", int'(bus.rt_ms),   0);
                check("c_to_cleared", int'(bus.timeout), 0);
            end
            bus.button = (k == 19);
`ifdef REACTION_FALSE_START_EN
            if (k == 19) sb_q.push_back(exp_t'{14'd0, 1'b0, 1'b1});
`else
            if (k == 99) begin
                bus.button = 1'b1;
                sb_q.push_back(exp_t'{14'd2, 1'b0, 1'b0});
            end
`endif
            if (bus.led_go) go_seen++;
            if (bus.led_go && first_go < 0) first_go = k;
            if (bus.done && done_k < 0) done_k = k;
        end
`ifdef REACTION_FALSE_START_EN
        check("c_led_go_never", go_seen, 0);
        check("c_done_cycle",   done_k,  20);
        check("c_fs_hold",      int'(bus.false_start), 1);
`else
        check("c_go_cycle",   first_go, 70);
        check("c_done_cycle", done_k,   100);
        check("c_fs_zero",    int'(bus.false_start), 0);
`endif

        // Round D: reset mid-GO (GO entered at k=50).
        bus.button   = 1'b0;
        bus.rand_val = 12'd0;
        bus.start    = 1'b1;
        for (int k = 0; k <= 60; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        check("d_in_go", int'(bus.led_go), 1);
        done_base = done_seen;
        rst = 1'b1;
        #1;
        check_all_zero("rst_go");
        @(negedge clk);
        check_all_zero("rst_go_edge");
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("d_no_done", done_seen - done_base, 0);
        check("d_idle_busy", int'(bus.busy), 0);

        // Round E: reset while rand_step is pending.
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("e_rand_step_before", int'(bus.rand_step), 1);
        rst = 1'b1;
        #1;
        check("e_rand_step_dropped", int'(bus.rand_step), 0);
        check("e_busy_dropped",      int'(bus.busy),      0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        check("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
